// File: rtl/rot_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rot_pkg
//  Description : Shared widths, direction encodings and the amount-mapping
//                helper used by the rotate stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package rot_pkg;

  localparam int ROT_W = 8;
  localparam int AMT_W = 3;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

  // A left rotate by n equals a right rotate by (0 - n) in 3-bit arithmetic,
  // so the core only ever needs to rotate right.
  function automatic logic [AMT_W-1:0] right_amount(input logic [AMT_W-1:0] amt,
                                                    input logic             dir);
    right_amount = (dir == DIR_LEFT) ? ({AMT_W{1'b0}} - amt) : amt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rot8_r.sv
`default_nettype none
// ============================================================================
//  Module      : rot8_r
//  Description : Purely combinational 8-bit right rotator,
//                y[i] = data[(i + s) mod 8], built as eight 8:1 muxes.
//  Revision    : 1.0 - initial release
// ============================================================================
module rot8_r
  import rot_pkg::*;
(
  input  logic [ROT_W-1:0] data,
  input  logic [AMT_W-1:0] s,
  output logic [ROT_W-1:0] y
);

  // One 8:1 mux per output bit; the 3-bit index add wraps modulo 8 for free.
  for (genvar i = 0; i < ROT_W; i++) begin : g_bit
    logic [AMT_W-1:0] w_idx;
    assign w_idx = AMT_W'(i) + s;
    assign y[i]  = data[w_idx];
  end

endmodule
`default_nettype wire

// File: rtl/rot_stage.sv
`default_nettype none
// ============================================================================
//  Module      : rot_stage
//  Description : Streaming rotate stage. Rotates each accepted byte in the
//                acceptance cycle and queues the result in a small FIFO, so
//                downstream stalls never reach the rotator core.
//  Revision    : 1.0 - initial release
// ============================================================================
module rot_stage
  import rot_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [ROT_W-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  input  logic             in_dir,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ROT_W-1:0] out_data,
  output logic [CNT_W-1:0] xfer_cnt
);

  localparam int             PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(DEPTH);

  logic [ROT_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [CNT_W-1:0] xfer_cnt_q, xfer_cnt_d;

  logic             w_push;
  logic             w_pop;
  logic [AMT_W-1:0] w_shift;
  logic [ROT_W-1:0] w_rot;

  // in_ready depends only on the registered count, never on out_ready.
  assign in_ready  = (count_q < DEPTH_CNT);
  assign out_valid = (count_q != '0);
  assign out_data  = mem_q[rd_ptr_q];
  assign xfer_cnt  = xfer_cnt_q;

  assign w_push  = in_valid & in_ready;
  assign w_pop   = out_valid & out_ready;
  assign w_shift = right_amount(in_amt, in_dir);

  rot8_r u_rot (
    .data (in_data),
    .s    (w_shift),
    .y    (w_rot)
  );

  // Next-state for pointers, occupancy and the accept counter.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    xfer_cnt_d = xfer_cnt_q;
    if (w_push) begin
      wr_ptr_d   = wr_ptr_q + PTR_W'(1);
      xfer_cnt_d = xfer_cnt_q + CNT_W'(1);
    end
    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state: cleared asynchronously so a reset drops all queued results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      xfer_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      xfer_cnt_q <= xfer_cnt_d;
    end
  end

  // Result storage is left unreset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= w_rot;
    end
  end

endmodule
`default_nettype wire
